// File: rtl/arb_mux_nparam_if.sv
// Handshake bundle for arb_mux_nparam: per-channel producer inputs, control,
// and the registered output stream with its status flags.
interface arb_mux_nparam_if #(
    parameter int N   = 4,
    parameter int X   = 16,
    parameter int S_W = 3
);
    logic [N*X-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [1:0]     mode;
    logic [S_W-1:0] s;
    logic [X-1:0]   out;
    logic           out_valid;
    logic           out_ready;
    logic [S_W-1:0] out_src;
    logic           sel_err;

    // Design-side view.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  mode,
        input  s,
        output out,
        output out_valid,
        input  out_ready,
        output out_src,
        output sel_err
    );

    // Producer/consumer-side view.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output mode,
        output s,
        input  out,
        input  out_valid,
        output out_ready,
        input  out_src,
        input  sel_err
    );
endinterface

// File: rtl/arb_mux_nparam.sv
// N-channel source-select mux with HOLD/FIXED/RR/PRIO arbitration, a single
// registered output stage and valid/ready backpressure on every side.
module arb_mux_nparam #(
    parameter int N   = 4,
    parameter int X   = 16,
    parameter int S_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    arb_mux_nparam_if.slave       bus
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_FIXED = 2'b01,
        MODE_RR    = 2'b10,
        MODE_PRIO  = 2'b11
    } mode_t;

    logic [X-1:0]   r_out;
    logic           r_out_valid;
    logic [S_W-1:0] r_out_src;
    logic           r_sel_err;
    logic [S_W-1:0] r_rr_ptr;

    mode_t          w_mode;
    logic           w_can_load;
    logic           w_grant_vld;
    logic [S_W-1:0] w_grant;
    logic [X-1:0]   w_sel_data;
    logic           w_sel_valid;
    logic [N-1:0]   w_in_ready;
    logic           w_xfer;
    logic           w_bad_sel;

    assign w_mode     = mode_t'(bus.mode);
    assign w_can_load = !r_out_valid || bus.out_ready;
    assign w_bad_sel  = (w_mode == MODE_FIXED) && (int'(bus.s) >= N);

    // Grant selection; RR searches upward from the channel after the last RR winner.
    always_comb begin
        logic found;
        found       = 1'b0;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        case (w_mode)
            MODE_FIXED: begin
                if (int'(bus.s) < N) begin
                    w_grant_vld = 1'b1;
                    w_grant     = bus.s;
                end
            end
            MODE_RR: begin
                for (int k = 1; k <= N; k++) begin
                    for (int i = 0; i < N; i++) begin
                        if (!found && bus.in_valid[i] &&
                            (((int'(r_rr_ptr) + k) % N) == i)) begin
                            found       = 1'b1;
                            w_grant_vld = 1'b1;
                            w_grant     = S_W'(i);
                        end
                    end
                end
            end
            MODE_PRIO: begin
                for (int i = 0; i < N; i++) begin
                    if (!found && bus.in_valid[i]) begin
                        found       = 1'b1;
                        w_grant_vld = 1'b1;
                        w_grant     = S_W'(i);
                    end
                end
            end
            default: begin
                w_grant_vld = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_vld && (w_grant == S_W'(i))) begin
                w_sel_data    = bus.in_data[i*X +: X];
                w_sel_valid   = bus.in_valid[i];
                w_in_ready[i] = w_can_load;
            end
        end
    end

    // A FIXED grant may be ready on an idle channel; only a valid one transfers.
    assign w_xfer = w_grant_vld && w_can_load && w_sel_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_sel_err   <= 1'b0;
            r_rr_ptr    <= S_W'(N - 1);
        end else begin
            if (w_xfer) begin
                r_out       <= w_sel_data;
                r_out_src   <= w_grant;
                r_out_valid <= 1'b1;
                if (w_mode == MODE_RR) begin
                    r_rr_ptr <= w_grant;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_bad_sel) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_src   = r_out_src;
    assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_arb_mux_nparam.sv
// Directed bench for arb_mux_nparam (N=4, X=16): a reference model predicts
// grants and queues expected words, which are popped when the DUT loads out.
module tb_arb_mux_nparam;
    localparam int N   = 4;
    localparam int X   = 16;
    localparam int S_W = 3;

    typedef struct {
        logic [X-1:0] d;
        int           src;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t q[$];
    int   m_ptr   = N - 1;
    logic [X-1:0] m_out = '0;
    int   m_src   = 0;
    bit   m_valid = 1'b0;
    bit   m_err   = 1'b0;

    arb_mux_nparam_if #(.N(N), .X(X), .S_W(S_W)) bus ();

    arb_mux_nparam #(.N(N), .X(X), .S_W(S_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_grant(input logic [1:0] md, input logic [2:0] sel,
                                        input logic [3:0] v, input int ptr,
                                        output bit ok, output int g);
        ok = 1'b0;
        g  = 0;
        case (md)
            2'b01: if (sel < N) begin ok = 1'b1; g = int'(sel); end
            2'b10: begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (ptr + 1 + k) % N;
                    if (!ok && v[c]) begin ok = 1'b1; g = c; end
                end
            end
            2'b11: begin
                for (int c = N - 1; c >= 0; c--) begin
                    if (v[c]) begin ok = 1'b1; g = c; end
                end
            end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic set_data(input logic [X-1:0] d0, input logic [X-1:0] d1,
                            input logic [X-1:0] d2, input logic [X-1:0] d3);
        bus.in_data = {d3, d2, d1, d0};
    endtask

    // One clock: check combinational readiness, predict, clock, check outputs.
    task automatic step(input string tag, input logic do_rst);
        bit          ok;
        int          g;
        bit          can_load;
        bit          xfer;
        logic [3:0]  exp_rdy;
        exp_t        e;
        #1;
        model_grant(bus.mode, bus.s, bus.in_valid, m_ptr, ok, g);
        can_load = !m_valid || bus.out_ready;
        exp_rdy  = (ok && can_load) ? (4'b0001 << g) : 4'b0000;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
        xfer = ok && can_load && bus.in_valid[g];
        if (xfer && !do_rst) begin
            e.d   = bus.in_data[g*X +: X];
            e.src = g;
            q.push_back(e);
        end
        rst = do_rst;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (do_rst) begin
            q.delete();
            m_ptr = N - 1; m_out = '0; m_src = 0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            if (bus.mode == 2'b01 && bus.s >= N) m_err = 1'b1;
            if (xfer) begin
                e = q.pop_front();
                m_out = e.d; m_src = e.src; m_valid = 1'b1;
                if (bus.mode == 2'b10) m_ptr = g;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".out"},       32'(bus.out),       32'(m_out));
        chk({tag, ".out_src"},   32'(bus.out_src),   32'(m_src));
        chk({tag, ".sel_err"},   32'(bus.sel_err),   32'(m_err));
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.mode      = 2'b00;
        bus.s         = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step("reset", 1'b1);
        chk("reset.out_const", 32'(bus.out), 32'h0);

        // FIXED s=2
        bus.mode = 2'b01; bus.s = 3'd2; bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
        set_data(16'h1111, 16'h2222, 16'hBEEF, 16'h4444);
        step("fixed2", 1'b0);
        chk("fixed2.out_const", 32'(bus.out), 32'hBEEF);
        chk("fixed2.src_const", 32'(bus.out_src), 32'd2);
        step("fixed2b", 1'b0);

        // RR with all channels valid: 0,1,2,3,0,1
        bus.mode = 2'b10; bus.in_valid = 4'b1111;
        set_data(16'hA000, 16'hA001, 16'hA002, 16'hA003);
        for (int i = 0; i < 6; i++) begin
            step("rr_all", 1'b0);
            chk("rr_all.seq", 32'(bus.out_src), 32'(i % N));
        end

        // PRIO with backpressure, then back-to-back reload
        bus.mode = 2'b11; bus.in_valid = 4'b1010;
        set_data(16'hB000, 16'hB001, 16'hB002, 16'hB003);
        step("prio_load", 1'b0);
        chk("prio_load.src_const", 32'(bus.out_src), 32'd1);
        bus.out_ready = 1'b0;
        set_data(16'hB000, 16'hC001, 16'hB002, 16'hB003);
        for (int i = 0; i < 5; i++) step("prio_stall", 1'b0);
        chk("prio_stall.out_const", 32'(bus.out), 32'hB001);
        bus.out_ready = 1'b1;
        step("prio_reload", 1'b0);
        chk("prio_reload.out_const", 32'(bus.out), 32'hC001);

        // HOLD drains without loading
        bus.mode = 2'b00; bus.in_valid = 4'b0001;
        step("hold_drain", 1'b0);
        step("hold_idle", 1'b0);

        // FIXED with out-of-range select, then RR keeps sticky error
        bus.mode = 2'b01; bus.s = 3'd5; bus.in_valid = 4'b1111;
        step("fixed_bad", 1'b0);
        bus.mode = 2'b10;
        step("err_sticky", 1'b0);
        step("err_clear", 1'b1);

        // RR mid-stream reset
        bus.mode = 2'b10; bus.in_valid = 4'b1111;
        set_data(16'hD000, 16'hD001, 16'hD002, 16'hD003);
        for (int i = 0; i < 3; i++) step("rr_mid", 1'b0);
        step("rr_rst", 1'b1);
        step("rr_after", 1'b0);
        chk("rr_after.src_const", 32'(bus.out_src), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arb_mux_nparam.md
Name: arb_mux_nparam

Overview:
- Parametrised N-channel, X-bit datapath source-select mux with a registered output stage and valid/ready handshakes on every input and on the output.
- Four run-time modes: hold, fixed select, round-robin, fixed priority.
- Generalises the datapath's combinational source mux to arbitrary channel count, with arbitration, a hold mode and backpressure.
- Sits between datapath producers (ALU, memory read, immediate, register file) and the datapath bus register.

Parameters:
- N, 4, number of input channels; legal range 2..8.
- X, 16, data width in bits.
- S_W, 3, select/source-index width; N <= 2**S_W is required.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  N*X  flattened channel data; channel i occupies bits [i*X+X-1 : i*X].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel ready; combinational, at most one bit high.
- mode  input  2  00 HOLD, 01 FIXED, 10 RR, 11 PRIO.
- s  input  S_W  channel index used in FIXED mode.
- out  output  X  registered output data.
- out_valid  output  1  output data valid.
- out_ready  input  1  downstream ready.
- out_src  output  S_W  index of the channel that produced the current out.
- sel_err  output  1  sticky error flag: FIXED mode selected with s >= N.

Behaviour:
- Reset: one clock, synchronous, active-high (rst=1 at a rising clk edge).
  - Values after reset: out=0, out_valid=0, out_src=0, sel_err=0, rr_ptr=N-1.
  - rst overrides any transfer in the same cycle, including a reset asserted mid-operation; the pending output word is discarded.
- can_load = !out_valid || out_ready.
- Grant g is combinational from mode, s, in_valid and rr_ptr:
  - HOLD: no grant; in_ready = 0.
  - FIXED: g = s if s < N, otherwise no grant.
  - RR: g = first i with in_valid[i]=1, searching (rr_ptr+1) mod N upward with wrap. No grant if no channel is valid.
  - PRIO: g = lowest i with in_valid[i]=1.
- in_ready[g] = can_load && (a grant exists); all other in_ready bits are 0.
  - In FIXED mode, in_ready[s] may be high while in_valid[s]=0. No transfer occurs in that case.
- Transfer: happens when in_valid[g] && in_ready[g]. On that clock edge: out <= channel g data, out_src <= g, out_valid <= 1.
- rr_ptr <= g on a transfer in RR mode only; PRIO and FIXED transfers leave rr_ptr unchanged.
- No transfer and out_ready=1: out_valid <= 0; out and out_src keep their last values.
- No transfer and out_ready=0: all output registers hold.
- Latency: an input accepted at edge k is visible on out at edge k (registered).
  - Full throughput is one word per clock when out_ready stays high.
  - Simultaneous drain and load in the same cycle is permitted.
- HOLD mode:
  - Freezes acceptance; an already-valid word can still drain through out_ready.
  - out keeps its value after draining.
- Mode and s changes take effect combinationally in the same cycle; there is no pipeline flush.
- sel_err <= 1 on any clock with mode=FIXED and s >= N. Only rst clears it.
- While out_valid=1 and out_ready=0, out and out_src are stable (AXI-style hold rule).
- Width rules: no arithmetic on data; rr_ptr wraps modulo N (not modulo 2**S_W).

Test Plan:
- Reset, then FIXED, s=2, in_valid=4'b0100, ch2=16'hBEEF, out_ready=1 -> next edge: out=16'hBEEF, out_src=2, out_valid=1; in_ready=4'b0100 throughout.
- RR, all four channels valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive edges; one word per clock.
- PRIO, in_valid=4'b1010, out_ready=0 after the first load -> first load is ch1; then in_ready=0, out is held stable for 5 cycles; when out_ready rises, ch1 reloads on the same edge as the drain (back-to-back).
- HOLD with out_valid=1 and ch0 valid, out_ready=1 -> word drains, out_valid=0 next edge, no new load, in_ready=0, out unchanged.
- FIXED with s=5 (N=4), all valid -> in_ready=0, no transfer, sel_err=1 on next edge and stays 1 after mode changes to RR; rst clears it to 0.
- RR mid-stream (rr_ptr=2, out_valid=1), assert rst for one cycle -> out=0, out_valid=0, out_src=0; first post-reset RR grant is ch0.
